// File: rtl/csa_pkg.sv
// Sizing helpers shared by the carry-save reduction pipeline.
package csa_pkg;

   localparam int unsigned MAX_OPS = 8;
   localparam int unsigned MIN_OPS = 3;

   // Operand count remaining after lvl levels of 3:2 compression.
   function automatic int unsigned csa_count(input int unsigned n, input int unsigned lvl);
      int unsigned c;
      c = n;
      for (int unsigned i = 0; i < lvl; i++)
         if (c > 2) c = c - c / 3;
      return c;
   endfunction

   function automatic int unsigned csa_levels(input int unsigned n);
      int unsigned c;
      int unsigned l;
      c = n;
      l = 0;
      for (int unsigned i = 0; i < MAX_OPS; i++)
         if (c > 2) begin
            c = c - c / 3;
            l++;
         end
      return l;
   endfunction

   // Bit offset of level lvl inside a bus that concatenates levels 0..lvl-1.
   function automatic int unsigned csa_offset(input int unsigned n, input int unsigned lvl,
                                              input int unsigned w);
      int unsigned o;
      o = 0;
      for (int unsigned i = 0; i < lvl; i++)
         o += csa_count(n, i) * w;
      return o;
   endfunction

endpackage

// File: rtl/csa_stage.sv
// One registered 3:2 reduction level; leftover operands pass through unchanged.
module csa_stage
   import csa_pkg::*;
#(
   parameter int unsigned N_IN  = 3,
   parameter int unsigned OW    = 8,
   parameter int unsigned TAG_W = 4
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  en,
   input  logic [N_IN*OW-1:0]                    in_vec,
   input  logic                                  in_valid,
   input  logic [TAG_W-1:0]                      in_tag,
   input  logic                                  in_signed,
   output logic [csa_count(N_IN, 1)*OW-1:0]      out_vec,
   output logic                                  out_valid,
   output logic [TAG_W-1:0]                      out_tag,
   output logic                                  out_signed
);

   localparam int unsigned NT = N_IN / 3;
   localparam int unsigned NO = csa_count(N_IN, 1);

   logic [NO*OW-1:0] nxt;

   for (genvar t = 0; t < NT; t++) begin : g_tri
      logic [OW-1:0] s;
      logic [OW-1:0] c;
      logic          unused_c_msb;

      for (genvar i = 0; i < OW; i++) begin : g_bit
         full_adder u_fa (
            .a    (in_vec[(3*t)*OW + i]),
            .b    (in_vec[(3*t+1)*OW + i]),
            .cin  (in_vec[(3*t+2)*OW + i]),
            .s    (s[i]),
            .cout (c[i])
         );
      end

      // Carry weight is doubled; the bit leaving the MSB is discarded (mod 2^OW).
      assign nxt[(2*t)*OW +: OW]   = s;
      assign nxt[(2*t+1)*OW +: OW] = {c[OW-2:0], 1'b0};
      assign unused_c_msb          = c[OW-1];
   end

   for (genvar r = 0; r < N_IN % 3; r++) begin : g_pass
      assign nxt[(2*NT+r)*OW +: OW] = in_vec[(3*NT+r)*OW +: OW];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_vec    <= '0;
         out_tag    <= '0;
         out_signed <= 1'b0;
      end else if (en) begin
         out_valid  <= in_valid;
         out_vec    <= nxt;
         out_tag    <= in_tag;
         out_signed <= in_signed;
      end
   end

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell used by the carry-save compressors.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/csa_reduce_pipe.sv
// Pipelined multi-operand adder: extension register, LEVELS carry-save levels, registered CPA.
module csa_reduce_pipe
   import csa_pkg::*;
#(
   parameter int unsigned WIDTH     = 16,
   parameter int unsigned NUM_OPS   = 4,
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned OUT_WIDTH = WIDTH + $clog2(NUM_OPS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_OPS*WIDTH-1:0] in_ops,
   input  logic                     in_signed,
   input  logic [TAG_W-1:0]         in_tag,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OUT_WIDTH-1:0]     out_sum,
   output logic [TAG_W-1:0]         out_tag
);

   localparam int unsigned LEVELS = csa_levels(NUM_OPS);
   localparam int unsigned BASE   = NUM_OPS * OUT_WIDTH;
   localparam int unsigned BUS_W  = csa_offset(NUM_OPS, LEVELS + 1, OUT_WIDTH) - BASE;
   localparam int unsigned FO     = csa_offset(NUM_OPS, LEVELS, OUT_WIDTH) - BASE;

   logic                 en;
   logic [BASE-1:0]      ext;
   logic [BASE-1:0]      front;
   logic                 f_valid;
   logic [TAG_W-1:0]     f_tag;
   logic                 f_sgn;
   logic [BUS_W-1:0]     bus;
   logic                 s_valid [LEVELS];
   logic [TAG_W-1:0]     s_tag   [LEVELS];
   logic                 s_sgn   [LEVELS];
   logic                 unused_sgn;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      ext = '0;
      for (int unsigned k = 0; k < NUM_OPS; k++) begin
         ext[k*OUT_WIDTH +: OUT_WIDTH] =
            {{(OUT_WIDTH-WIDTH){in_signed & in_ops[k*WIDTH + WIDTH - 1]}}, in_ops[k*WIDTH +: WIDTH]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_valid <= 1'b0;
         front   <= '0;
         f_tag   <= '0;
         f_sgn   <= 1'b0;
      end else if (en) begin
         f_valid <= in_valid;
         front   <= ext;
         f_tag   <= in_tag;
         f_sgn   <= in_signed;
      end
   end

   // Level l's vectors occupy a fixed slice of bus; widths shrink level by level.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int unsigned NI = csa_count(NUM_OPS, l);
      localparam int unsigned NO = csa_count(NUM_OPS, l + 1);
      localparam int unsigned OO = csa_offset(NUM_OPS, l + 1, OUT_WIDTH) - BASE;

      logic [NI*OUT_WIDTH-1:0] v_in;
      logic                    i_valid;
      logic [TAG_W-1:0]        i_tag;
      logic                    i_sgn;

      if (l == 0) begin : g_src
         assign v_in    = front;
         assign i_valid = f_valid;
         assign i_tag   = f_tag;
         assign i_sgn   = f_sgn;
      end else begin : g_src
         localparam int unsigned IO = csa_offset(NUM_OPS, l, OUT_WIDTH) - BASE;
         assign v_in    = bus[IO +: NI*OUT_WIDTH];
         assign i_valid = s_valid[l-1];
         assign i_tag   = s_tag[l-1];
         assign i_sgn   = s_sgn[l-1];
      end

      csa_stage #(
         .N_IN  (NI),
         .OW    (OUT_WIDTH),
         .TAG_W (TAG_W)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .en         (en),
         .in_vec     (v_in),
         .in_valid   (i_valid),
         .in_tag     (i_tag),
         .in_signed  (i_sgn),
         .out_vec    (bus[OO +: NO*OUT_WIDTH]),
         .out_valid  (s_valid[l]),
         .out_tag    (s_tag[l]),
         .out_signed (s_sgn[l])
      );
   end

   assign unused_sgn = s_sgn[LEVELS-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_tag   <= '0;
      end else if (en) begin
         out_valid <= s_valid[LEVELS-1];
         out_sum   <= bus[FO +: OUT_WIDTH] + bus[FO+OUT_WIDTH +: OUT_WIDTH];
         out_tag   <= s_tag[LEVELS-1];
      end
   end

endmodule

// File: tb/tb_csa_reduce_pipe.sv
// Directed and randomized checks of csa_reduce_pipe against an arithmetic reference.
module tb_csa_reduce_pipe;

   localparam int unsigned W  = 8;
   localparam int unsigned N  = 4;
   localparam int unsigned TW = 4;
   localparam int unsigned OW = 10;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst;
   logic          in_valid, in_ready, in_signed, out_valid, out_ready;
   logic [N*W-1:0] in_ops;
   logic [TW-1:0] in_tag, out_tag;
   logic [OW-1:0] out_sum;

   csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(N), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ops(in_ops),
      .in_signed(in_signed), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_tag(out_tag)
   );

   // Parameter-sweep instances, all fed all-ones unsigned operands.
   logic        sw_valid;
   logic        sw_sgn = 1'b0;
   logic        sw_rdy = 1'b1;
   logic [TW-1:0] sw_tag = '0;
   logic [3*W-1:0] s3_ops = '1;
   logic [5*W-1:0] s5_ops = '1;
   logic [8*W-1:0] s8_ops = '1;
   logic        s3_ir, s5_ir, s8_ir, s3_ov, s5_ov, s8_ov;
   logic [9:0]  s3_sum;
   logic [10:0] s5_sum, s8_sum;
   logic [TW-1:0] s3_tag, s5_tag, s8_tag;

   csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(3), .TAG_W(TW)) dut3 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s3_ir), .in_ops(s3_ops),
      .in_signed(sw_sgn), .in_tag(sw_tag), .out_valid(s3_ov), .out_ready(sw_rdy),
      .out_sum(s3_sum), .out_tag(s3_tag)
   );
   csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(5), .TAG_W(TW)) dut5 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s5_ir), .in_ops(s5_ops),
      .in_signed(sw_sgn), .in_tag(sw_tag), .out_valid(s5_ov), .out_ready(sw_rdy),
      .out_sum(s5_sum), .out_tag(s5_tag)
   );
   csa_reduce_pipe #(.WIDTH(W), .NUM_OPS(8), .TAG_W(TW)) dut8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(s8_ir), .in_ops(s8_ops),
      .in_signed(sw_sgn), .in_tag(sw_tag), .out_valid(s8_ov), .out_ready(sw_rdy),
      .out_sum(s8_sum), .out_tag(s8_tag)
   );

   typedef struct packed {
      logic [OW-1:0] sum;
      logic [TW-1:0] tag;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned n_deliv = 0;

   function automatic logic [OW-1:0] ref_sum(input logic [N*W-1:0] ops, input logic sgn);
      int          acc;
      int          v;
      logic [W-1:0] b;
      acc = 0;
      for (int k = 0; k < N; k++) begin
         b = ops[k*W +: W];
         v = b;
         if (sgn && v >= 128) v = v - 256;
         acc = acc + v;
      end
      return acc[OW-1:0];
   endfunction

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] want);
      n_vec++;
      assert (obs === want) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, want);
      end
   endtask

   // One clock: score the output transfer and record the input transfer of this edge.
   task automatic cycle();
      exp_t e;
      #1;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("sb_sum", 32'(out_sum), 32'(e.sum));
               chk("sb_tag", 32'(out_tag), 32'(e.tag));
               n_deliv++;
            end
         end
         if (in_valid && in_ready) begin
            e.sum = ref_sum(in_ops, in_signed);
            e.tag = in_tag;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic wait_out(input string name);
      int k;
      k = 0;
      while (!out_valid && k < 20) begin
         cycle();
         k++;
      end
      chk(name, 32'(out_valid), 1);
   endtask

   task automatic drive(input logic v, input logic [N*W-1:0] ops, input logic sgn,
                        input logic [TW-1:0] tag);
      in_valid  = v;
      in_ops    = ops;
      in_signed = sgn;
      in_tag    = tag;
   endtask

   initial begin
      logic [OW-1:0] hs;
      logic [TW-1:0] ht;
      int unsigned   d0;
      int            lat3, lat5, lat8;
      logic [10:0]   v3, v5, v8;

      rst = 1'b1;
      out_ready = 1'b0;
      sw_valid = 1'b0;
      drive(1'b0, '0, 1'b0, '0);
      @(posedge clk);
      #1;
      cycle();
      cycle();
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_sum", 32'(out_sum), 0);
      chk("rst_out_tag", 32'(out_tag), 0);
      chk("rst_in_ready", 32'(in_ready), 1);
      rst = 1'b0;

      // Unsigned max with latency
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 4'd3);
      #1 chk("umax_in_ready", 32'(in_ready), 1);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      cycle();
      chk("umax_lat1", 32'(out_valid), 0);
      cycle();
      chk("umax_lat2", 32'(out_valid), 0);
      cycle();
      chk("umax_lat3", 32'(out_valid), 1);
      chk("umax_sum", 32'(out_sum), 32'h3FC);
      chk("umax_tag", 32'(out_tag), 3);
      cycle();
      chk("umax_single", 32'(out_valid), 0);

      // Signed min, then mixed signed
      drive(1'b1, 32'h8080_8080, 1'b1, 4'd5);
      cycle();
      drive(1'b1, {8'hFF, 8'h01, 8'h80, 8'h7F}, 1'b1, 4'd6);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      wait_out("smin_wait");
      chk("smin_sum", 32'(out_sum), 32'h200);
      cycle();
      chk("mixed_valid", 32'(out_valid), 1);
      chk("mixed_sum", 32'(out_sum), 32'h3FF);
      cycle();

      // Bubble propagates as exactly one empty output slot
      drive(1'b1, 32'h0102_0304, 1'b0, 4'd1);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      cycle();
      drive(1'b1, 32'h1020_3040, 1'b0, 4'd2);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      cycle();
      chk("bubble_a", 32'(out_valid), 1);
      cycle();
      chk("bubble_gap", 32'(out_valid), 0);
      cycle();
      chk("bubble_b", 32'(out_valid), 1);
      cycle();

      // Streaming: 16 back-to-back groups
      d0 = n_deliv;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, $urandom(), 1'($urandom_range(0, 1)), 4'($urandom()));
         #1 chk("stream_in_ready", 32'(in_ready), 1);
         cycle();
      end
      drive(1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         chk("stream_tail_valid", 32'(out_valid), 1);
         cycle();
      end
      chk("stream_count", n_deliv - d0, 16);
      chk("stream_drained", 32'(out_valid), 0);

      // Backpressure: hold a result for 5 cycles
      d0 = n_deliv;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, $urandom(), 1'($urandom_range(0, 1)), 4'($urandom()));
         cycle();
      end
      drive(1'b0, '0, 1'b0, '0);
      wait_out("bp_wait");
      out_ready = 1'b0;
      drive(1'b1, $urandom(), 1'b1, 4'hA);
      hs = out_sum;
      ht = out_tag;
      for (int i = 0; i < 5; i++) begin
         #1 chk("bp_in_ready", 32'(in_ready), 0);
         cycle();
         chk("bp_valid_hold", 32'(out_valid), 1);
         chk("bp_sum_hold", 32'(out_sum), 32'(hs));
         chk("bp_tag_hold", 32'(out_tag), 32'(ht));
      end
      out_ready = 1'b1;
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      for (int i = 0; i < 8; i++) cycle();
      chk("bp_count", n_deliv - d0, 4);
      chk("bp_queue_empty", exp_q.size(), 0);

      // Reset with two groups in flight
      drive(1'b1, $urandom(), 1'b0, 4'h7);
      cycle();
      drive(1'b1, $urandom(), 1'b1, 4'h8);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_mid_valid", 32'(out_valid), 0);
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk("rst_mid_flushed", 32'(out_valid), 0);
      end
      drive(1'b1, 32'h1111_2222, 1'b0, 4'h9);
      cycle();
      drive(1'b0, '0, 1'b0, '0);
      cycle();
      cycle();
      chk("rst_new_early", 32'(out_valid), 0);
      cycle();
      chk("rst_new_valid", 32'(out_valid), 1);
      chk("rst_new_tag", 32'(out_tag), 9);
      cycle();

      // Parameter sweep
      lat3 = 0; lat5 = 0; lat8 = 0;
      v3 = '0; v5 = '0; v8 = '0;
      sw_valid = 1'b1;
      cycle();
      sw_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         cycle();
         if (s3_ov && lat3 == 0) begin lat3 = k; v3 = 11'(s3_sum); end
         if (s5_ov && lat5 == 0) begin lat5 = k; v5 = s5_sum; end
         if (s8_ov && lat8 == 0) begin lat8 = k; v8 = s8_sum; end
      end
      chk("sweep3_lat", lat3, 2);
      chk("sweep3_sum", 32'(v3), 765);
      chk("sweep5_lat", lat5, 4);
      chk("sweep5_sum", 32'(v5), 1275);
      chk("sweep8_lat", lat8, 5);
      chk("sweep8_sum", 32'(v8), 2040);

      // Random traffic with random backpressure
      for (int i = 0; i < 200; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom(), 1'($urandom_range(0, 1)), 4'($urandom()));
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      drive(1'b0, '0, 1'b0, '0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_drained", 32'(out_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
